// File: rtl/cpu_reg_client_if.sv
// Bundled request, operand, writeback and register-file signals for cpu_reg_client.
// The slave modport is the client's view and the master modport is its environment's view.
interface cpu_reg_client_if;
    logic        i_read_valid;
    logic        o_read_ready;
    logic [4:0]  i_read_rs1_idx;
    logic [4:0]  i_read_rs2_idx;

    logic        o_operand_valid;
    logic        i_operand_ready;
    logic [31:0] o_operand_rs1;
    logic [31:0] o_operand_rs2;

    logic        i_wb_valid;
    logic        o_wb_ready;
    logic [4:0]  i_wb_rd_idx;
    logic [31:0] i_wb_rd;

    logic [7:0]  o_read_tag;
    logic [4:0]  o_read_rs1_idx;
    logic [4:0]  o_read_rs2_idx;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;

    logic [7:0]  o_write_tag;
    logic [4:0]  o_write_rd_idx;
    logic [31:0] o_rd;

    modport slave (
        input  i_read_valid, i_read_rs1_idx, i_read_rs2_idx,
        input  i_operand_ready,
        input  i_wb_valid, i_wb_rd_idx, i_wb_rd,
        input  i_rs1, i_rs2,
        output o_read_ready,
        output o_operand_valid, o_operand_rs1, o_operand_rs2,
        output o_wb_ready,
        output o_read_tag, o_read_rs1_idx, o_read_rs2_idx,
        output o_write_tag, o_write_rd_idx, o_rd
    );

    modport master (
        output i_read_valid, i_read_rs1_idx, i_read_rs2_idx,
        output i_operand_ready,
        output i_wb_valid, i_wb_rd_idx, i_wb_rd,
        output i_rs1, i_rs2,
        input  o_read_ready,
        input  o_operand_valid, o_operand_rs1, o_operand_rs2,
        input  o_wb_ready,
        input  o_read_tag, o_read_rs1_idx, o_read_rs2_idx,
        input  o_write_tag, o_write_rd_idx, o_rd
    );
endinterface

// File: rtl/cpu_reg_client.sv
// Tag-signalled register-file client: two-operand reads and writebacks.
// Define CPU_REG_CLIENT_BYPASS_EN to forward a same-edge write instead of stalling the read.
module cpu_reg_client (
    input  logic            i_clock,
    input  logic            i_reset,
    cpu_reg_client_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StWait, StData} state_e;

    state_e      state_q, state_d;
    logic [7:0]  read_tag_q, write_tag_q;
    logic [4:0]  rs1_idx_q, rs2_idx_q, wr_idx_q;
    logic [31:0] rd_q;
    logic [31:0] op_rs1_q, op_rs2_q;
    logic        op_valid_q;

    logic        read_ready;
    logic        read_fire;
    logic        latch_op;
    logic        op_fire;
    logic        stall;
    logic [31:0] rs1_val, rs2_val;

`ifdef CPU_REG_CLIENT_BYPASS_EN
    logic        byp_valid_q;
    logic [4:0]  byp_idx_q;
    logic [31:0] byp_data_q;

    assign stall   = 1'b0;
    assign rs1_val = (byp_valid_q && byp_idx_q == rs1_idx_q) ? byp_data_q : bus.i_rs1;
    assign rs2_val = (byp_valid_q && byp_idx_q == rs2_idx_q) ? byp_data_q : bus.i_rs2;

    // The register file misses a write taken on the read's own edge, so keep it aside.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            byp_valid_q <= 1'b0;
            byp_idx_q   <= '0;
            byp_data_q  <= '0;
        end else if (read_fire) begin
            byp_valid_q <= bus.i_wb_valid && (bus.i_wb_rd_idx != 5'd0);
            byp_idx_q   <= bus.i_wb_rd_idx;
            byp_data_q  <= bus.i_wb_rd;
        end else if (op_fire) begin
            byp_valid_q <= 1'b0;
        end
    end
`else
    // Hold the read off one cycle so the conflicting write reaches the register file first.
    assign stall   = bus.i_wb_valid && (bus.i_wb_rd_idx != 5'd0) &&
                     (bus.i_wb_rd_idx == bus.i_read_rs1_idx ||
                      bus.i_wb_rd_idx == bus.i_read_rs2_idx);
    assign rs1_val = bus.i_rs1;
    assign rs2_val = bus.i_rs2;
`endif

    always_comb begin
        state_d    = state_q;
        read_ready = 1'b0;
        latch_op   = 1'b0;
        op_fire    = 1'b0;
        case (state_q)
            StIdle: begin
                read_ready = !i_reset && !stall;
                if (bus.i_read_valid && read_ready) begin
                    state_d = StWait;
                end
            end
            StWait: state_d = StData;
            StData: begin
                if (!op_valid_q) begin
                    latch_op = 1'b1;
                end else if (bus.i_operand_ready) begin
                    op_fire = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign read_fire = bus.i_read_valid && read_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= StIdle;
            read_tag_q  <= '0;
            write_tag_q <= '0;
            rs1_idx_q   <= '0;
            rs2_idx_q   <= '0;
            wr_idx_q    <= '0;
            rd_q        <= '0;
            op_rs1_q    <= '0;
            op_rs2_q    <= '0;
            op_valid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (read_fire) begin
                rs1_idx_q  <= bus.i_read_rs1_idx;
                rs2_idx_q  <= bus.i_read_rs2_idx;
                read_tag_q <= read_tag_q + 8'd1;
            end
            if (bus.i_wb_valid) begin
                wr_idx_q    <= bus.i_wb_rd_idx;
                rd_q        <= bus.i_wb_rd;
                write_tag_q <= write_tag_q + 8'd1;
            end
            if (latch_op) begin
                op_rs1_q   <= rs1_val;
                op_rs2_q   <= rs2_val;
                op_valid_q <= 1'b1;
            end else if (op_fire) begin
                op_valid_q <= 1'b0;
            end
        end
    end

    assign bus.o_read_ready    = read_ready;
    assign bus.o_operand_valid = op_valid_q;
    assign bus.o_operand_rs1   = op_rs1_q;
    assign bus.o_operand_rs2   = op_rs2_q;
    assign bus.o_wb_ready      = 1'b1;
    assign bus.o_read_tag      = read_tag_q;
    assign bus.o_read_rs1_idx  = rs1_idx_q;
    assign bus.o_read_rs2_idx  = rs2_idx_q;
    assign bus.o_write_tag     = write_tag_q;
    assign bus.o_write_rd_idx  = wr_idx_q;
    assign bus.o_rd            = rd_q;

endmodule
